mem_arbiter: RTL

- Sits directly downstream of the pipelined RV32I datapath's two memory ports (instruction fetch, data load/store).
- Serialises both onto one shared memory port using a valid/response handshake.
- Returns read data and a one-cycle response pulse to the requesting side, so the pipeline can stall on outstanding accesses.
- Round-robin fairness; data wins the first tie after reset.

---
 rtl/arb_types.sv | 37 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/arb_types.sv
// Shared types for the two-port memory arbiter: FSM states, request sources
// and the round-robin grant decision.
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_src_t;

    // On a tie the side that did not win last time is granted.
    function automatic arb_src_t pick_grant(
        input logic     instr_elig,
        input logic     data_elig,
        input arb_src_t last
    );
        arb_src_t pick;
        if (instr_elig && data_elig) begin
            if (last == INSTR) begin
                pick = DATA;
            end else begin
                pick = INSTR;
            end
        end else if (data_elig) begin
            pick = DATA;
        end else begin
            pick = INSTR;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises the instruction-fetch and load/store
// ports onto one shared memory port, one outstanding request at a time.
module mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_read,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic [DATA_W-1:0]   instr_rdata,
    output logic                instr_resp,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_mbe,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mbe,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    localparam int MBE_W = DATA_W / 8;

    arb_state_t         state_q, state_d;
    arb_src_t           last_grant_q, last_grant_d;
    arb_src_t           grant;

    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
    logic [MBE_W-1:0]   req_mbe_q, req_mbe_d;
    logic               req_read_q, req_read_d;
    logic               req_write_q, req_write_d;

    logic [DATA_W-1:0]  instr_rdata_q, instr_rdata_d;
    logic               instr_resp_q, instr_resp_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
    logic               data_resp_q, data_resp_d;

    logic               instr_elig;
    logic               data_elig;
    logic               grant_fire;

    // A requester still holding its request during its resp cycle must not be re-served.
    assign instr_elig = instr_read & ~instr_resp_q;
    assign data_elig  = (data_read | data_write) & ~data_resp_q;
    assign grant      = pick_grant(instr_elig, data_elig, last_grant_q);
    assign grant_fire = (state_q == IDLE) && (instr_elig || data_elig);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= INSTR;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    last_grant_d = grant;
                    if (grant == DATA) begin
                        state_d = SERVE_D;
                    end else begin
                        state_d = SERVE_I;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state_q)
            SERVE_I: mem_read = 1'b1;
            SERVE_D: begin
                mem_write = req_write_q;
                mem_read  = req_read_q & ~req_write_q;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign mem_addr    = req_addr_q;
    assign mem_wdata   = req_wdata_q;
    assign mem_mbe     = req_mbe_q;
    assign instr_rdata = instr_rdata_q;
    assign instr_resp  = instr_resp_q;
    assign data_rdata  = data_rdata_q;
    assign data_resp   = data_resp_q;

    // Request capture: the shared port is driven only from these registers.
    always_comb begin
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_mbe_d   = req_mbe_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        if (grant_fire) begin
            if (grant == DATA) begin
                req_addr_d  = data_addr;
                req_wdata_d = data_wdata;
                req_mbe_d   = data_mbe;
                req_write_d = data_write;
                req_read_d  = data_read & ~data_write;
            end else begin
                req_addr_d  = instr_addr;
                req_wdata_d = '0;
                req_mbe_d   = '0;
                req_write_d = 1'b0;
                req_read_d  = 1'b1;
            end
        end
    end

    always_comb begin
        instr_resp_d  = (state_q == SERVE_I) && mem_resp;
        data_resp_d   = (state_q == SERVE_D) && mem_resp;
        instr_rdata_d = instr_resp_d ? mem_rdata : instr_rdata_q;
        data_rdata_d  = data_resp_d  ? mem_rdata : data_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_mbe_q     <= '0;
            req_read_q    <= 1'b0;
            req_write_q   <= 1'b0;
            instr_rdata_q <= '0;
            instr_resp_q  <= 1'b0;
            data_rdata_q  <= '0;
            data_resp_q   <= 1'b0;
        end else begin
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_mbe_q     <= req_mbe_d;
            req_read_q    <= req_read_d;
            req_write_q   <= req_write_d;
            instr_rdata_q <= instr_rdata_d;
            instr_resp_q  <= instr_resp_d;
            data_rdata_q  <= data_rdata_d;
            data_resp_q   <= data_resp_d;
        end
    end

endmodule
